// File: rtl/gpio_pkg.sv
// Shared constants, types and helpers for the GPIO event controller.
// The build macro GPIO_DEBOUNCE_EN selects the debounced input path.
package gpio_pkg;

    localparam int unsigned GPIO_MIN_SYNC_STAGES = 2;

    typedef struct packed {
        logic rise_en;
        logic fall_en;
        logic clear;
    } chan_ctrl_t;

    // Counter must hold 0..cycles without wrapping; never narrower than 1 bit.
    function automatic int unsigned dbnc_cnt_w(input int unsigned cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/gpio_in_chan.sv
// One input channel: CDC sync chain, optional debounce, edge detect and sticky status bit.
// Debounce counter exists only when GPIO_DEBOUNCE_EN is defined.
module gpio_in_chan
    import gpio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       pad_i,
    input  chan_ctrl_t ctrl_i,
    output logic       level_o,
    output logic       status_o
);

    if (SYNC_STAGES < GPIO_MIN_SYNC_STAGES || DEBOUNCE_CYCLES < 1) begin : g_cfg_err
        $error("gpio_in_chan: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_last;
    logic                   level_q, level_d;
    logic                   status_q, status_d;
    logic                   rise_evt, fall_evt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned      CNT_W    = dbnc_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A mismatch must be seen DEBOUNCE_CYCLES edges in a row before the level flips.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_last == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync_last;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        level_d = sync_last;
    end
`endif

    assign rise_evt = ~level_q &  level_d & ctrl_i.rise_en;
    assign fall_evt =  level_q & ~level_d & ctrl_i.fall_en;

    // A new event wins over a write-one-to-clear arriving in the same cycle.
    always_comb begin
        status_d = (status_q & ~ctrl_i.clear) | rise_evt | fall_evt;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            level_q  <= 1'b0;
            status_q <= 1'b0;
        end else begin
            level_q  <= level_d;
            status_q <= status_d;
        end
    end

    assign level_o  = level_q;
    assign status_o = status_q;

endmodule

// File: rtl/gpio_event_ctrl.sv
// GPIO block between the AHB-Lite register file and the pads: per-channel input
// event logic, masked interrupt and output register. Optional macro: GPIO_DEBOUNCE_EN.
module gpio_event_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned          OUTPUT_IO       = 8,
    parameter int unsigned          INPUT_IO        = 8,
    parameter int unsigned          SYNC_STAGES     = 2,
    parameter int unsigned          DEBOUNCE_CYCLES = 16,
    parameter logic [OUTPUT_IO-1:0] OUT_RESET_VAL   = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INPUT_IO-1:0]  ext_input_io,
    output logic [OUTPUT_IO-1:0] ext_output_io,
    output logic [INPUT_IO-1:0]  ahbl_input_io,
    input  logic [INPUT_IO-1:0]  ahbl_rise_en,
    input  logic [INPUT_IO-1:0]  ahbl_fall_en,
    input  logic [INPUT_IO-1:0]  ahbl_irq_mask,
    output logic [INPUT_IO-1:0]  ahbl_status,
    input  logic [INPUT_IO-1:0]  ahbl_clear_status,
    output logic                 ahbl_irq,
    input  logic                 ahbl_out_wr_en,
    input  logic [OUTPUT_IO-1:0] ahbl_out_wdata,
    input  logic [OUTPUT_IO-1:0] ahbl_out_set,
    input  logic [OUTPUT_IO-1:0] ahbl_out_clr
);

    logic [OUTPUT_IO-1:0] out_q, out_d;
    logic                 irq_q, irq_d;

    for (genvar i = 0; i < INPUT_IO; i++) begin : g_in
        chan_ctrl_t ctrl;

        assign ctrl = '{rise_en: ahbl_rise_en[i],
                        fall_en: ahbl_fall_en[i],
                        clear:   ahbl_clear_status[i]};

        gpio_in_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk_i    (clk),
            .reset_i  (reset),
            .pad_i    (ext_input_io[i]),
            .ctrl_i   (ctrl),
            .level_o  (ahbl_input_io[i]),
            .status_o (ahbl_status[i])
        );
    end

    always_comb begin
        irq_d = |(ahbl_status & ahbl_irq_mask);
    end

    // Write, then set, then clear: clear has the final word on any bit.
    always_comb begin
        out_d = ahbl_out_wr_en ? ahbl_out_wdata : out_q;
        out_d = (out_d | ahbl_out_set) & ~ahbl_out_clr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= OUT_RESET_VAL;
            irq_q <= 1'b0;
        end else begin
            out_q <= out_d;
            irq_q <= irq_d;
        end
    end

    assign ext_output_io = out_q;
    assign ahbl_irq      = irq_q;

endmodule

// File: tb/tb_gpio_event_ctrl.sv
// Directed bench for gpio_event_ctrl: output-register vector table plus
// hand-written input event sequences; follows GPIO_DEBOUNCE_EN when defined.
module tb_gpio_event_ctrl;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DB   = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = SYNC + DB;
`else
    localparam int LAT = SYNC + 1;
`endif
    localparam logic [7:0] RST_OUT = 8'h3C;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ext_input_io;
    logic [7:0] ext_output_io;
    logic [7:0] ahbl_input_io;
    logic [7:0] ahbl_rise_en;
    logic [7:0] ahbl_fall_en;
    logic [7:0] ahbl_irq_mask;
    logic [7:0] ahbl_status;
    logic [7:0] ahbl_clear_status;
    logic       ahbl_irq;
    logic       ahbl_out_wr_en;
    logic [7:0] ahbl_out_wdata;
    logic [7:0] ahbl_out_set;
    logic [7:0] ahbl_out_clr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gpio_event_ctrl #(
        .OUTPUT_IO       (8),
        .INPUT_IO        (8),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB),
        .OUT_RESET_VAL   (RST_OUT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ext_input_io      (ext_input_io),
        .ext_output_io     (ext_output_io),
        .ahbl_input_io     (ahbl_input_io),
        .ahbl_rise_en      (ahbl_rise_en),
        .ahbl_fall_en      (ahbl_fall_en),
        .ahbl_irq_mask     (ahbl_irq_mask),
        .ahbl_status       (ahbl_status),
        .ahbl_clear_status (ahbl_clear_status),
        .ahbl_irq          (ahbl_irq),
        .ahbl_out_wr_en    (ahbl_out_wr_en),
        .ahbl_out_wdata    (ahbl_out_wdata),
        .ahbl_out_set      (ahbl_out_set),
        .ahbl_out_clr      (ahbl_out_clr)
    );

    typedef struct {
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] set;
        logic [7:0] clr;
        logic [7:0] exp_out;
    } ovec_t;

    ovec_t ov[8];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    initial begin
        ov[0] = '{wr: 1'b1, wdata: 8'hA5, set: 8'h00, clr: 8'h00, exp_out: 8'hA5};
        ov[1] = '{wr: 1'b0, wdata: 8'h00, set: 8'h02, clr: 8'h00, exp_out: 8'hA7};
        ov[2] = '{wr: 1'b0, wdata: 8'h00, set: 8'h02, clr: 8'h02, exp_out: 8'hA5};
        ov[3] = '{wr: 1'b1, wdata: 8'h00, set: 8'h81, clr: 8'h00, exp_out: 8'h81};
        ov[4] = '{wr: 1'b0, wdata: 8'h00, set: 8'h00, clr: 8'h01, exp_out: 8'h80};
        ov[5] = '{wr: 1'b1, wdata: 8'hFF, set: 8'h00, clr: 8'h0F, exp_out: 8'hF0};
        ov[6] = '{wr: 1'b0, wdata: 8'h00, set: 8'h00, clr: 8'h00, exp_out: 8'hF0};
        ov[7] = '{wr: 1'b0, wdata: 8'h00, set: 8'h0F, clr: 8'hF0, exp_out: 8'h0F};

        reset             = 1'b1;
        ext_input_io      = '0;
        ahbl_rise_en      = '0;
        ahbl_fall_en      = '0;
        ahbl_irq_mask     = '0;
        ahbl_clear_status = '0;
        ahbl_out_wr_en    = 1'b0;
        ahbl_out_wdata    = '0;
        ahbl_out_set      = '0;
        ahbl_out_clr      = '0;

        tick(2);
        chk("rst out", ext_output_io, RST_OUT);
        chk("rst level", ahbl_input_io, 8'h00);
        chk("rst status", ahbl_status, 8'h00);
        chk("rst irq", {7'b0, ahbl_irq}, 8'h00);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            ahbl_out_wr_en = ov[i].wr;
            ahbl_out_wdata = ov[i].wdata;
            ahbl_out_set   = ov[i].set;
            ahbl_out_clr   = ov[i].clr;
            tick(1);
            chk($sformatf("out vec%0d", i), ext_output_io, ov[i].exp_out);
        end
        ahbl_out_wr_en = 1'b0;
        ahbl_out_wdata = '0;
        ahbl_out_set   = '0;
        ahbl_out_clr   = '0;

        // Rising edge on ch0 with irq masked in.
        ahbl_rise_en    = 8'h01;
        ahbl_irq_mask   = 8'h01;
        ext_input_io[0] = 1'b1;
        tick(LAT - 1);
        chk("A level early", ahbl_input_io, 8'h00);
        chk("A status early", ahbl_status, 8'h00);
        tick(1);
        chk("A level", ahbl_input_io, 8'h01);
        chk("A status", ahbl_status, 8'h01);
        chk("A irq early", {7'b0, ahbl_irq}, 8'h00);
        tick(1);
        chk("A irq", {7'b0, ahbl_irq}, 8'h01);
        ahbl_clear_status = 8'h01;
        tick(1);
        ahbl_clear_status = 8'h00;
        chk("A clr status", ahbl_status, 8'h00);
        chk("A clr irq lag", {7'b0, ahbl_irq}, 8'h01);
        tick(1);
        chk("A clr irq", {7'b0, ahbl_irq}, 8'h00);

        // Falling edge only on ch5.
        ahbl_rise_en    = 8'h00;
        ahbl_fall_en    = 8'h20;
        ahbl_irq_mask   = 8'h20;
        ext_input_io[5] = 1'b1;
        tick(LAT + 1);
        chk("B rise level", ahbl_input_io, 8'h21);
        chk("B rise no flag", ahbl_status, 8'h00);
        ext_input_io[5] = 1'b0;
        tick(LAT - 1);
        chk("B fall early", ahbl_status, 8'h00);
        tick(1);
        chk("B fall status", ahbl_status, 8'h20);
        chk("B fall level", ahbl_input_io, 8'h01);
        tick(1);
        chk("B irq", {7'b0, ahbl_irq}, 8'h01);
        ahbl_fall_en = 8'h00;
        tick(1);
        chk("B en off keeps", ahbl_status, 8'h20);
        ahbl_fall_en    = 8'h20;
        ext_input_io[5] = 1'b1;
        tick(LAT + 1);
        chk("B rise no new", ahbl_status, 8'h20);
        chk("B level back", ahbl_input_io, 8'h21);
        ahbl_clear_status = 8'h20;
        tick(1);
        ahbl_clear_status = 8'h00;
        chk("B clr status", ahbl_status, 8'h00);
        chk("B clr irq lag", {7'b0, ahbl_irq}, 8'h01);
        tick(1);
        chk("B clr irq", {7'b0, ahbl_irq}, 8'h00);

        // Event and clear in the same cycle on ch1; irq masked off.
        ahbl_rise_en    = 8'h02;
        ahbl_fall_en    = 8'h00;
        ahbl_irq_mask   = 8'h00;
        ext_input_io[1] = 1'b1;
        tick(LAT - 1);
        ahbl_clear_status = 8'h02;
        tick(1);
        ahbl_clear_status = 8'h00;
        chk("C set beats clr", ahbl_status, 8'h02);
        chk("C level", ahbl_input_io, 8'h23);
        tick(2);
        chk("C masked irq", {7'b0, ahbl_irq}, 8'h00);
        ahbl_irq_mask = 8'h02;
        tick(1);
        chk("C unmask irq", {7'b0, ahbl_irq}, 8'h01);
        ahbl_clear_status = 8'h02;
        tick(1);
        ahbl_clear_status = 8'h00;
        chk("C clr status", ahbl_status, 8'h00);
        tick(1);
        chk("C clr irq", {7'b0, ahbl_irq}, 8'h00);
        ahbl_clear_status = 8'h02;
        tick(1);
        ahbl_clear_status = 8'h00;
        chk("C clr idle", ahbl_status, 8'h00);

        // 3-cycle then 4-cycle pulse on ch2.
        ahbl_rise_en    = 8'h04;
        ahbl_fall_en    = 8'h04;
        ahbl_irq_mask   = 8'h00;
        ext_input_io[2] = 1'b1;
        tick(3);
        ext_input_io[2] = 1'b0;
        tick(12);
        chk("D short level", ahbl_input_io, 8'h23);
`ifdef GPIO_DEBOUNCE_EN
        chk("D short status", ahbl_status, 8'h00);
`else
        chk("D short status", ahbl_status, 8'h04);
`endif
        ahbl_clear_status = 8'h04;
        tick(1);
        ahbl_clear_status = 8'h00;
        chk("D short clr", ahbl_status, 8'h00);
        ext_input_io[2] = 1'b1;
        if (LAT > 4) begin
            tick(4);
            ext_input_io[2] = 1'b0;
            tick(LAT - 4);
        end else begin
            tick(LAT);
        end
        chk("D long level", ahbl_input_io, 8'h27);
        chk("D long status", ahbl_status, 8'h04);
        if (LAT <= 4) begin
            tick(4 - LAT);
            ext_input_io[2] = 1'b0;
        end
        tick(12);
        chk("D settle level", ahbl_input_io, 8'h23);
        ahbl_irq_mask = 8'h04;
        tick(1);
        chk("D irq", {7'b0, ahbl_irq}, 8'h01);

        // Reset mid-sync with a pending flag, then pads held high through reset.
        ext_input_io = 8'hF3;
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("E rst level", ahbl_input_io, 8'h00);
        chk("E rst status", ahbl_status, 8'h00);
        chk("E rst irq", {7'b0, ahbl_irq}, 8'h00);
        chk("E rst out", ext_output_io, RST_OUT);
        tick(1);
        ahbl_rise_en  = 8'hFF;
        ahbl_fall_en  = 8'h00;
        ahbl_irq_mask = 8'hFF;
        reset         = 1'b0;
        tick(LAT - 1);
        chk("E post early", ahbl_status, 8'h00);
        tick(1);
        chk("E post status", ahbl_status, 8'hF3);
        chk("E post level", ahbl_input_io, 8'hF3);
        tick(1);
        chk("E post irq", {7'b0, ahbl_irq}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
